// File: rtl/ingress_arbiter_pkg.sv
// ingress_arbiter_pkg -- shared definitions for the ingress arbiter slice.
//   state_t   : arbiter FSM state encoding
//   HDR_WORDS : header words presented to the destination calculator per packet
//   DEST_W    : width of the destination identifier
//   WORD_W    : ingress/egress data word width
package ingress_arbiter_pkg;

  localparam int unsigned HDR_WORDS = 3;
  localparam int unsigned DEST_W    = 2;
  localparam int unsigned WORD_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAD,
    DEST,
    FWD,
    DRAIN
  } state_t;

endpackage

// File: rtl/ingress_arbiter_rr.sv
// rr_arbiter -- 4-way round-robin selector.
//   req [3:0] : request vector
//   ptr [1:0] : index of the last granted requester; search starts at ptr+1
//   gnt [3:0] : one-hot grant (all zero when no request)
//   idx [1:0] : index of the granted requester
//   any       : at least one request present
module rr_arbiter (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] idx,
  output logic       any
);

  always_comb begin
    logic [1:0] cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr + 2'(k + 1);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/ingress_arbiter.sv
// ingress_arbiter -- grants one of four ingress ports per packet, feeds the
// first three words to an external destination calculator, then forwards the
// packet (buffered header replay followed by pass-through) tagged with the
// returned destination. Runt packets (eop within the header) are discarded.
//
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   in_valid/in_sop/in_eop     : per-port word qualifiers
//   in_data                    : per-port 16-bit words, port i at [16i+15:16i]
//   in_ready                   : per-port accept
//   calc_valid/calc_data       : header words to the destination calculator
//   calc_dest_valid/calc_dest  : calculator result
//   out_valid/out_sop/out_eop/out_data/out_dest, out_ready : egress stream
//   grant_id                   : current owner port
//   drop                       : one-cycle pulse per discarded packet
//
// Build option: INGRESS_TIMEOUT_EN adds a stall watchdog (TIMEOUT_CYCLES idle
// cycles of the owner in HDR discards via PAD, in FWD terminates via DRAIN).
module ingress_arbiter
  import ingress_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [NUM_PORTS-1:0]        in_sop,
  input  logic [NUM_PORTS-1:0]        in_eop,
  input  logic [NUM_PORTS*WORD_W-1:0] in_data,
  output logic [NUM_PORTS-1:0]        in_ready,
  output logic                        calc_valid,
  output logic [WORD_W-1:0]           calc_data,
  input  logic                        calc_dest_valid,
  input  logic [DEST_W-1:0]           calc_dest,
  output logic                        out_valid,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic [WORD_W-1:0]           out_data,
  output logic [DEST_W-1:0]           out_dest,
  input  logic                        out_ready,
  output logic [1:0]                  grant_id,
  output logic                        drop
);

  localparam logic [1:0] LAST = 2'(HDR_WORDS - 1);
  // rd_idx == PASS means the header replay is finished and words come
  // straight from the granted port.
  localparam logic [1:0] PASS = 2'(HDR_WORDS);

  state_t              state, state_nxt;
  logic [1:0]          last_ptr;
  logic [WORD_W-1:0]   hdr_buf [HDR_WORDS];
  logic [1:0]          hdr_cnt;
  logic [1:0]          rd_idx;
  logic                discard;
  logic                eop_hdr;
  logic [DEST_W-1:0]   dest_q;

  logic                g_valid, g_eop;
  logic [WORD_W-1:0]   g_data;
  logic [3:0]          arb_gnt;
  logic [1:0]          arb_idx;
  logic                arb_any;
  logic                timeout;

  assign g_valid  = in_valid[grant_id];
  assign g_eop    = in_eop[grant_id];
  assign g_data   = in_data[WORD_W*grant_id +: WORD_W];
  assign out_dest = dest_q;

  rr_arbiter u_rr (
    .req (in_valid & in_sop),
    .ptr (last_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

`ifdef INGRESS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_cnt;
  logic             counting;

  // The replay phase is excluded: the owner is not being read then, and
  // leaving mid-replay would break a word already presented on the egress.
  assign counting = (state == HDR) || ((state == FWD) && (rd_idx == PASS));
  assign timeout  = counting && !g_valid &&
                    (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             stall_cnt <= '0;
    else if (!counting || g_valid || timeout) stall_cnt <= '0;
    else                                   stall_cnt <= stall_cnt + CNT_W'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    in_ready   = '0;
    calc_valid = 1'b0;
    calc_data  = '0;
    out_valid  = 1'b0;
    out_sop    = 1'b0;
    out_eop    = 1'b0;
    out_data   = '0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) state_nxt = HDR;
      end
      HDR: begin
        in_ready[grant_id] = 1'b1;
        calc_valid         = g_valid;
        calc_data          = g_valid ? g_data : '0;
        if (g_valid) begin
          if (hdr_cnt == LAST) state_nxt = DEST;
          else if (g_eop)      state_nxt = PAD;
        end else if (timeout) begin
          state_nxt = PAD;
        end
      end
      PAD: begin
        calc_valid = 1'b1;
        if (hdr_cnt == LAST) state_nxt = DEST;
      end
      DEST: begin
        if (calc_dest_valid) begin
          drop      = discard;
          state_nxt = discard ? IDLE : FWD;
        end
      end
      FWD: begin
        if (rd_idx != PASS) begin
          out_valid = 1'b1;
          out_data  = hdr_buf[rd_idx];
          out_sop   = (rd_idx == 2'd0);
          out_eop   = (rd_idx == LAST) && eop_hdr;
        end else begin
          // in_sop is deliberately ignored here; it travels as plain data.
          out_valid          = g_valid;
          out_data           = g_data;
          out_eop            = g_eop;
          in_ready[grant_id] = out_ready;
          if (timeout) state_nxt = DRAIN;
        end
        if (out_valid && out_ready && out_eop) state_nxt = IDLE;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_eop   = 1'b1;
        if (out_ready) begin
          drop      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant_id <= '0;
      last_ptr <= 2'd3;
      for (int unsigned i = 0; i < HDR_WORDS; i++) hdr_buf[i] <= '0;
      hdr_cnt  <= '0;
      rd_idx   <= '0;
      discard  <= 1'b0;
      eop_hdr  <= 1'b0;
      dest_q   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant_id <= arb_idx;
            last_ptr <= arb_idx;
            hdr_cnt  <= '0;
            discard  <= 1'b0;
            eop_hdr  <= 1'b0;
          end
        end
        HDR: begin
          if (g_valid) begin
            hdr_buf[hdr_cnt] <= g_data;
            hdr_cnt          <= hdr_cnt + 2'd1;
            if (hdr_cnt == LAST) eop_hdr <= g_eop;
            else if (g_eop)      discard <= 1'b1;
          end else if (timeout) begin
            discard <= 1'b1;
          end
        end
        PAD: begin
          hdr_buf[hdr_cnt] <= '0;
          hdr_cnt          <= hdr_cnt + 2'd1;
        end
        DEST: begin
          if (calc_dest_valid) begin
            dest_q <= calc_dest;
            rd_idx <= '0;
          end
        end
        FWD: begin
          if ((rd_idx != PASS) && out_ready) rd_idx <= rd_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
